// File: rtl/cpu_issue_ctrl_pkg.sv
// Shared definitions for the decode-side issue controller: FSM state
// encodings, the nop opcode used after reset, and the moxie opcode bytes
// whose instructions carry a 32-bit big-endian operand.
package cpu_issue_ctrl_pkg;

    // Gather FSM states
    localparam logic [1:0] S_OPC  = 2'd0;  // waiting for an opcode halfword
    localparam logic [1:0] S_OPHI = 2'd1;  // waiting for operand[31:16]
    localparam logic [1:0] S_OPLO = 2'd2;  // waiting for operand[15:0]

    localparam logic [15:0] NOP_OPCODE = 16'h0F00;

    // Opcode[15:8] values of the long (opcode + 32-bit operand) forms
    localparam logic [7:0] OPB_LDI_L = 8'h01;
    localparam logic [7:0] OPB_JSRA  = 8'h03;
    localparam logic [7:0] OPB_LDA_L = 8'h08;
    localparam logic [7:0] OPB_STA_L = 8'h09;
    localparam logic [7:0] OPB_LDO_L = 8'h0C;
    localparam logic [7:0] OPB_STO_L = 8'h0D;
    localparam logic [7:0] OPB_JMPA  = 8'h1A;
    localparam logic [7:0] OPB_LDI_B = 8'h1B;
    localparam logic [7:0] OPB_LDA_B = 8'h1D;
    localparam logic [7:0] OPB_STA_B = 8'h1F;
    localparam logic [7:0] OPB_LDI_S = 8'h20;
    localparam logic [7:0] OPB_LDA_S = 8'h22;
    localparam logic [7:0] OPB_STA_S = 8'h24;
    localparam logic [7:0] OPB_LDO_B = 8'h36;
    localparam logic [7:0] OPB_STO_B = 8'h37;
    localparam logic [7:0] OPB_LDO_S = 8'h38;
    localparam logic [7:0] OPB_STO_S = 8'h39;

    // True when the opcode high byte names a long form. Every listed byte
    // has bit 7 clear, so all opcode[15]==1 forms fall out as short.
    function automatic logic is_long_opcode(input logic [7:0] opb);
        logic r;
        case (opb)
            OPB_LDI_L, OPB_JSRA,  OPB_LDA_L, OPB_STA_L,
            OPB_LDO_L, OPB_STO_L, OPB_JMPA,  OPB_LDI_B,
            OPB_LDA_B, OPB_STA_B, OPB_LDI_S, OPB_LDA_S,
            OPB_STA_S, OPB_LDO_B, OPB_STO_B, OPB_LDO_S,
            OPB_STO_S: r = 1'b1;
            default:   r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cpu_issue_ctrl_insn_len.sv
// cpu_insn_len: combinational opcode-byte to instruction-length decoder.
// Shared with fetch for prefetch sizing.
module cpu_insn_len
    import cpu_issue_ctrl_pkg::*;
(
    input  logic [7:0] opcode_hi_i,
    output logic       is_long_o
);

    // Long forms are followed by two operand halfwords
    always_comb begin
        is_long_o = is_long_opcode(opcode_hi_i);
    end

endmodule

// File: rtl/cpu_issue_ctrl.sv
// cpu_issue_ctrl: gathers variable-length moxie instructions from the fetch
// halfword stream and presents them to decode with stall/flush handling.
// Optional build macro CPU_ISSUE_PERF_EN adds the issue_count_o counter.
module cpu_issue_ctrl
    import cpu_issue_ctrl_pkg::*;
#(
    parameter int PC_WIDTH = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [15:0]         hw_i,
    input  logic [PC_WIDTH-1:0] hw_pc_i,
    input  logic                hw_valid_i,
    output logic                hw_ready_o,
    input  logic                stall_i,
    input  logic                flush_i,
    output logic [15:0]         opcode_o,
    output logic [31:0]         operand_o,
    output logic                valid_o,
    output logic [PC_WIDTH-1:0] PC_o,
`ifdef CPU_ISSUE_PERF_EN
    output logic [31:0]         issue_count_o,
`endif
    output logic                busy_o
);

    logic [1:0]          state_q,   state_d;
    logic                valid_q,   valid_d;
    logic [15:0]         opcode_q,  opcode_d;
    logic [31:0]         operand_q, operand_d;
    logic [PC_WIDTH-1:0] pc_q,      pc_d;
    // Partial long instruction: opcode, its PC and the operand high half
    logic [15:0]         lopc_q,    lopc_d;
    logic [PC_WIDTH-1:0] lpc_q,     lpc_d;
    logic [15:0]         hi_q,      hi_d;

    logic is_long;
    logic out_free;
    logic accept;

    cpu_insn_len u_insn_len (
        .opcode_hi_i (hw_i[15:8]),
        .is_long_o   (is_long)
    );

    // Handshake: the output slot is free when empty or being consumed now;
    // operand high halves need no output slot, so S_OPHI accepts even when stalled
    always_comb begin
        out_free   = !valid_q || !stall_i;
        hw_ready_o = !flush_i &&
                     (((state_q == S_OPC) && out_free) ||
                      (state_q == S_OPHI) ||
                      ((state_q == S_OPLO) && out_free));
        accept     = hw_valid_i && hw_ready_o;
    end

    // Next-state: flush wins, otherwise advance the gather FSM on accept
    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q && stall_i;   // consumer takes it when not stalled
        opcode_d  = opcode_q;
        operand_d = operand_q;
        pc_d      = pc_q;
        lopc_d    = lopc_q;
        lpc_d     = lpc_q;
        hi_d      = hi_q;
        if (flush_i) begin
            state_d = S_OPC;
            valid_d = 1'b0;
        end else if (accept) begin
            case (state_q)
                S_OPC: begin
                    if (is_long) begin
                        lopc_d  = hw_i;
                        lpc_d   = hw_pc_i;
                        state_d = S_OPHI;
                    end else begin
                        opcode_d  = hw_i;
                        operand_d = 32'h0;
                        pc_d      = hw_pc_i;
                        valid_d   = 1'b1;
                    end
                end
                S_OPHI: begin
                    hi_d    = hw_i;
                    state_d = S_OPLO;
                end
                S_OPLO: begin
                    opcode_d  = lopc_q;
                    pc_d      = lpc_q;
                    operand_d = {hi_q, hw_i};
                    valid_d   = 1'b1;
                    state_d   = S_OPC;
                end
                default: state_d = S_OPC;
            endcase
        end else if ((state_q != S_OPC) && (state_q != S_OPHI) && (state_q != S_OPLO)) begin
            // Unused encoding never accepts; return to a legal state
            state_d = S_OPC;
        end
    end

    // State and output registers; reset presents a nop that is not valid
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= S_OPC;
            valid_q   <= 1'b0;
            opcode_q  <= NOP_OPCODE;
            operand_q <= 32'h0;
            pc_q      <= '0;
            lopc_q    <= NOP_OPCODE;
            lpc_q     <= '0;
            hi_q      <= 16'h0;
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            opcode_q  <= opcode_d;
            operand_q <= operand_d;
            pc_q      <= pc_d;
            lopc_q    <= lopc_d;
            lpc_q     <= lpc_d;
            hi_q      <= hi_d;
        end
    end

`ifdef CPU_ISSUE_PERF_EN
    logic [31:0] issue_cnt_q;

    // Count instructions taken by decode; flush does not clear it, wraps naturally
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            issue_cnt_q <= 32'h0;
        end else if (valid_q && !stall_i) begin
            issue_cnt_q <= issue_cnt_q + 32'h1;
        end
    end

    assign issue_count_o = issue_cnt_q;
`endif

    assign opcode_o  = opcode_q;
    assign operand_o = operand_q;
    assign valid_o   = valid_q;
    assign PC_o      = pc_q;
    assign busy_o    = (state_q != S_OPC);

endmodule

// File: tb/tb_cpu_issue_ctrl.sv
// Directed self-checking bench for cpu_issue_ctrl. Inputs change 1 time unit
// after the rising edge; outputs are checked at the same point.
module tb_cpu_issue_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [15:0] hw_i;
    logic [31:0] hw_pc_i;
    logic        hw_valid_i;
    logic        hw_ready_o;
    logic        stall_i;
    logic        flush_i;
    logic [15:0] opcode_o;
    logic [31:0] operand_o;
    logic        valid_o;
    logic [31:0] PC_o;
    logic        busy_o;
`ifdef CPU_ISSUE_PERF_EN
    logic [31:0] issue_count_o;
`endif

    int checks = 0;
    int errors = 0;

    cpu_issue_ctrl #(.PC_WIDTH(32)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .hw_i       (hw_i),
        .hw_pc_i    (hw_pc_i),
        .hw_valid_i (hw_valid_i),
        .hw_ready_o (hw_ready_o),
        .stall_i    (stall_i),
        .flush_i    (flush_i),
        .opcode_o   (opcode_o),
        .operand_o  (operand_o),
        .valid_o    (valid_o),
        .PC_o       (PC_o),
`ifdef CPU_ISSUE_PERF_EN
        .issue_count_o (issue_count_o),
`endif
        .busy_o     (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] h, input logic [31:0] pc);
        hw_valid_i = v;
        hw_i       = h;
        hw_pc_i    = pc;
    endtask

    initial begin
        rst_i = 1'b0;
        stall_i = 1'b0;
        flush_i = 1'b0;
        drive(1'b0, 16'h0, 32'h0);
        tick();
        tick();

        // Reset state
        chk("rst_valid",  valid_o, 0);
        chk("rst_busy",   busy_o, 0);
        chk("rst_opcode", opcode_o, 16'h0F00);
        chk("rst_operand", operand_o, 0);
        chk("rst_pc",     PC_o, 0);
        chk("rst_ready",  hw_ready_o, 1);

        // Reset mid-operation: long opcode accepted, then async reset
        rst_i = 1'b1;
        drive(1'b1, 16'h0100, 32'h10);
        tick();
        chk("mid_busy", busy_o, 1);
        drive(1'b0, 16'h0, 32'h0);
        rst_i = 1'b0;
        #1;
        chk("async_busy",   busy_o, 0);
        chk("async_valid",  valid_o, 0);
        chk("async_opcode", opcode_o, 16'h0F00);
        tick();
        rst_i = 1'b1;

        // Short stream back-to-back
        drive(1'b1, 16'h0523, 32'h20);
        tick();
        chk("s1_valid",   valid_o, 1);
        chk("s1_opcode",  opcode_o, 16'h0523);
        chk("s1_operand", operand_o, 0);
        chk("s1_pc",      PC_o, 32'h20);
        drive(1'b1, 16'h8A05, 32'h22);
        tick();
        chk("s2_valid",   valid_o, 1);
        chk("s2_opcode",  opcode_o, 16'h8A05);
        chk("s2_pc",      PC_o, 32'h22);
        chk("s2_busy",    busy_o, 0);
        drive(1'b0, 16'h0, 32'h0);
        tick();
        chk("s_drain_valid", valid_o, 0);

        // Long instruction
        drive(1'b1, 16'h0130, 32'h1000);
        tick();
        chk("l1_busy",  busy_o, 1);
        chk("l1_valid", valid_o, 0);
        drive(1'b1, 16'hDEAD, 32'h1002);
        tick();
        chk("l2_busy",  busy_o, 1);
        chk("l2_valid", valid_o, 0);
        drive(1'b1, 16'hBEEF, 32'h1004);
        tick();
        chk("l3_valid",   valid_o, 1);
        chk("l3_busy",    busy_o, 0);
        chk("l3_opcode",  opcode_o, 16'h0130);
        chk("l3_operand", operand_o, 32'hDEADBEEF);
        chk("l3_pc",      PC_o, 32'h1000);

        // Stall hold for 3 cycles with a short opcode waiting
        stall_i = 1'b1;
        drive(1'b1, 16'h0523, 32'h30);
        #1;
        chk("st_ready", hw_ready_o, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("st_valid",   valid_o, 1);
            chk("st_opcode",  opcode_o, 16'h0130);
            chk("st_operand", operand_o, 32'hDEADBEEF);
            chk("st_pc",      PC_o, 32'h1000);
            chk("st_ready_c", hw_ready_o, 0);
        end
        stall_i = 1'b0;
        tick();
        chk("st_next_opcode",  opcode_o, 16'h0523);
        chk("st_next_pc",      PC_o, 32'h30);
        chk("st_next_operand", operand_o, 0);
        chk("st_next_valid",   valid_o, 1);
        drive(1'b0, 16'h0, 32'h0);
        tick();
        chk("st_drain_valid", valid_o, 0);

        // Flush in the middle of a long instruction
        drive(1'b1, 16'h1A00, 32'h40);
        tick();
        chk("f1_busy", busy_o, 1);
        drive(1'b1, 16'h0000, 32'h42);
        tick();
        chk("f2_busy", busy_o, 1);
        flush_i = 1'b1;
        drive(1'b1, 16'h1234, 32'h44);
        #1;
        chk("f_ready", hw_ready_o, 0);
        tick();
        chk("f_busy",  busy_o, 0);
        chk("f_valid", valid_o, 0);
        flush_i = 1'b0;
        drive(1'b1, 16'h0400, 32'h50);
        tick();
        chk("f_next_valid",   valid_o, 1);
        chk("f_next_opcode",  opcode_o, 16'h0400);
        chk("f_next_operand", operand_o, 0);
        chk("f_next_pc",      PC_o, 32'h50);

        // Flush while stalled still drops the valid instruction
        drive(1'b0, 16'h0, 32'h0);
        stall_i = 1'b1;
        flush_i = 1'b1;
        tick();
        chk("fs_valid", valid_o, 0);
        flush_i = 1'b0;
        stall_i = 1'b0;

        // Operand halfwords still accepted while stalled in S_OPHI
        drive(1'b1, 16'h0300, 32'h60);
        tick();
        chk("h1_busy", busy_o, 1);
        stall_i = 1'b1;
        drive(1'b1, 16'h1111, 32'h62);
        #1;
        chk("h_ready_ophi", hw_ready_o, 1);
        tick();
        chk("h2_busy", busy_o, 1);
        stall_i = 1'b0;
        drive(1'b1, 16'h2222, 32'h64);
        tick();
        chk("h3_valid",   valid_o, 1);
        chk("h3_opcode",  opcode_o, 16'h0300);
        chk("h3_operand", operand_o, 32'h11112222);
        chk("h3_pc",      PC_o, 32'h60);
        drive(1'b0, 16'h0, 32'h0);
        tick();
        chk("h_drain_valid", valid_o, 0);

`ifdef CPU_ISSUE_PERF_EN
        // Taken since reset: 0523, 8A05, 0130, 0523, 0300 (0400 was flushed while stalled)
        chk("perf_count", issue_count_o, 32'd5);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
